// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - FP16 format constants shared by the float_MAC datapath
package fp16_pkg;

  localparam int EXP_W        = 5;
  localparam int FRAC_W       = 10;
  localparam int FP16_BIAS    = 15;
  localparam int FP16_EXP_MAX = 31;

  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_INF  = 16'h7C00;

  function automatic logic [15:0] fp16_signed_zero(input logic sign);
    return {sign, 15'h0000};
  endfunction

  function automatic logic [15:0] fp16_signed_inf(input logic sign);
    return {sign, FP16_INF[14:0]};
  endfunction

endpackage

// File: rtl/fp16_unpack.sv
// rtl/fp16_unpack.sv - combinational FP16 field split and operand classification
module fp16_unpack
  import fp16_pkg::*;
(
  input  logic [15:0]       value,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [FRAC_W:0]   man,
  output logic              is_zero,
  output logic              is_inf,
  output logic              is_nan
);

  logic [FRAC_W-1:0] frac;
  logic              exp_all_ones;

  assign sign = value[15];
  assign exp  = value[14:10];
  assign frac = value[9:0];

  // Subnormal inputs are flushed: any zero exponent counts as zero.
  assign man          = {1'b1, frac};
  assign exp_all_ones = (exp == EXP_W'(FP16_EXP_MAX));
  assign is_zero      = (exp == '0);
  assign is_inf       = exp_all_ones && (frac == '0);
  assign is_nan       = exp_all_ones && (frac != '0);

endmodule

// File: rtl/fpmultiplier.sv
// rtl/fpmultiplier.sv - 3-stage pipelined FP16 multiplier, RNE rounding, flush-to-zero
module fpmultiplier
  import fp16_pkg::*;
(
  input  logic        CLK,
  input  logic        RESETn,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        in_valid,
  output logic [15:0] product,
  output logic        out_valid
);

  localparam logic [7:0]        BIAS_8    = 8'(FP16_BIAS);
  localparam logic signed [7:0] EXP_MAX_S = 8'(FP16_EXP_MAX);

  logic              a_sign, b_sign;
  logic [EXP_W-1:0]  a_exp, b_exp;
  logic [FRAC_W:0]   a_man, b_man;
  logic              a_zero, a_inf, a_nan;
  logic              b_zero, b_inf, b_nan;

  fp16_unpack u_unpack_a (
    .value   (A),
    .sign    (a_sign),
    .exp     (a_exp),
    .man     (a_man),
    .is_zero (a_zero),
    .is_inf  (a_inf),
    .is_nan  (a_nan)
  );

  fp16_unpack u_unpack_b (
    .value   (B),
    .sign    (b_sign),
    .exp     (b_exp),
    .man     (b_man),
    .is_zero (b_zero),
    .is_inf  (b_inf),
    .is_nan  (b_nan)
  );

  logic        sign_s0;
  logic        spec_s0;
  logic [15:0] specval_s0;

  always_comb begin
    sign_s0    = a_sign ^ b_sign;
    spec_s0    = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    specval_s0 = fp16_signed_zero(sign_s0);
    if (a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf)) begin
      specval_s0 = FP16_QNAN;
    end else if (a_inf | b_inf) begin
      specval_s0 = fp16_signed_inf(sign_s0);
    end
  end

  // Stage 1 registers
  logic                v1;
  logic                sign1;
  logic signed [7:0]   exp1;
  logic [FRAC_W:0]     man1a, man1b;
  logic                spec1;
  logic [15:0]         specval1;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      v1 <= 1'b0;
    end else begin
      v1 <= in_valid;
    end
  end

  always_ff @(posedge CLK) begin
    sign1    <= sign_s0;
    exp1     <= {3'b000, a_exp} + {3'b000, b_exp} - BIAS_8;
    man1a    <= a_man;
    man1b    <= b_man;
    spec1    <= spec_s0;
    specval1 <= specval_s0;
  end

  // Stage 2 registers
  logic                v2;
  logic [21:0]         prod2;
  logic                sign2;
  logic signed [7:0]   exp2;
  logic                spec2;
  logic [15:0]         specval2;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      v2 <= 1'b0;
    end else begin
      v2 <= v1;
    end
  end

  always_ff @(posedge CLK) begin
    prod2    <= man1a * man1b;
    sign2    <= sign1;
    exp2     <= exp1;
    spec2    <= spec1;
    specval2 <= specval1;
  end

  // Stage 3: normalize, round to nearest even, range check, pack
  logic [FRAC_W-1:0]   frac_n;
  logic                guard, sticky, inc;
  logic signed [7:0]   exp_n, exp_r;
  logic [FRAC_W-1:0]   frac_r;
  logic                carry;
  logic [15:0]         result;

  always_comb begin
    if (prod2[21]) begin
      frac_n = prod2[20:11];
      guard  = prod2[10];
      sticky = |prod2[9:0];
      exp_n  = exp2 + 8'sd1;
    end else begin
      frac_n = prod2[19:10];
      guard  = prod2[9];
      sticky = |prod2[8:0];
      exp_n  = exp2;
    end

    inc             = guard & (sticky | frac_n[0]);
    {carry, frac_r} = {1'b0, frac_n} + {{FRAC_W{1'b0}}, inc};
    exp_r           = exp_n + {7'b0000000, carry};

    if (spec2) begin
      result = specval2;
    end else if (exp_r >= EXP_MAX_S) begin
      result = fp16_signed_inf(sign2);
    end else if (exp_r <= 8'sd0) begin
      result = fp16_signed_zero(sign2);
    end else begin
      result = {sign2, exp_r[EXP_W-1:0], frac_r};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      out_valid <= 1'b0;
      product   <= 16'h0000;
    end else begin
      out_valid <= v2;
      if (v2) begin
        product <= result;
      end
    end
  end

endmodule

// File: tb/tb_fpmultiplier.sv
// tb/tb_fpmultiplier.sv - self-checking bench for fpmultiplier
module tb_fpmultiplier;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] A = 16'h0000;
  logic [15:0] B = 16'h0000;
  logic [15:0] product;
  logic        out_valid;

  fpmultiplier dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .A         (A),
    .B         (B),
    .in_valid  (in_valid),
    .product   (product),
    .out_valid (out_valid)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        v;
    logic [15:0] p;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] p;
  } vec_t;

  exp_t        pipe[$];
  logic [15:0] last_prod = 16'h0000;
  int          passed = 0;
  int          total = 0;

  // Reference: exact integer significand product, rounded by remainder comparison.
  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int  ea, eb, fa, fb, e, sh, half;
    longint m, q, r;
    logic s;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [15:0] res;
    s      = a[15] ^ b[15];
    ea     = int'(a[14:10]);
    eb     = int'(b[14:10]);
    fa     = int'(a[9:0]);
    fb     = int'(b[9:0]);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    a_inf  = (ea == 31) && (fa == 0);
    b_inf  = (eb == 31) && (fb == 0);
    a_nan  = (ea == 31) && (fa != 0);
    b_nan  = (eb == 31) && (fb != 0);
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) return 16'h7E00;
    if (a_inf || b_inf) return {s, 15'h7C00};
    if (a_zero || b_zero) return {s, 15'h0000};
    m    = longint'(1024 + fa) * longint'(1024 + fb);
    sh   = (m >= 64'd2097152) ? 11 : 10;
    e    = ea + eb - 15 + (sh - 10);
    q    = m >> sh;
    r    = m - (q << sh);
    half = 1 << (sh - 1);
    if (r > half || (r == half && q[0])) q = q + 1;
    if (q == 2048) begin
      q = 1024;
      e = e + 1;
    end
    if (e >= 31) return {s, 15'h7C00};
    if (e <= 0) return {s, 15'h0000};
    res = {s, e[4:0], q[9:0]};
    return res;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic step(input logic rst_n, input logic v, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] expp, input string tag);
    exp_t e;
    RESETn   = rst_n;
    in_valid = v;
    A        = a;
    B        = b;
    @(posedge CLK);
    #1;
    if (!rst_n) begin
      pipe.delete();
      pipe.push_back('0);
      pipe.push_back('0);
      last_prod = 16'h0000;
      chk({tag, "_rst_valid"}, {15'b0, out_valid}, 16'h0000);
      chk({tag, "_rst_product"}, product, 16'h0000);
    end else begin
      pipe.push_back({v, expp});
      e = pipe.pop_front();
      if (e.v) last_prod = e.p;
      chk({tag, "_valid"}, {15'b0, out_valid}, {15'b0, e.v});
      chk({tag, "_product"}, product, last_prod);
    end
  endtask

  task automatic go(input logic v, input logic [15:0] a, input logic [15:0] b, input string tag);
    step(1'b1, v, a, b, ref_mul(a, b), tag);
  endtask

  function automatic logic [15:0] rand_operand();
    logic [15:0] x;
    x = 16'($urandom);
    if ($urandom_range(3) != 0) x[14:10] = 5'($urandom_range(22, 6));
    return x;
  endfunction

  vec_t vecs[$];
  logic [15:0] stream_a[10];
  logic [15:0] stream_b[10];

  initial begin
    int n;

    vecs.push_back('{16'h3C00, 16'h3C00, 16'h3C00});
    vecs.push_back('{16'h4000, 16'hC200, 16'hC600});
    vecs.push_back('{16'h3C01, 16'h3C01, 16'h3C02});
    vecs.push_back('{16'h3C01, 16'h3E00, 16'h3E02});
    vecs.push_back('{16'h7BFF, 16'h4000, 16'h7C00});
    vecs.push_back('{16'h0400, 16'h0400, 16'h0000});
    vecs.push_back('{16'h8400, 16'h0400, 16'h8000});
    vecs.push_back('{16'h7C00, 16'h0000, 16'h7E00});
    vecs.push_back('{16'h7E01, 16'h3C00, 16'h7E00});
    vecs.push_back('{16'hFC00, 16'h4000, 16'hFC00});
    vecs.push_back('{16'h0001, 16'h5000, 16'h0000});
    vecs.push_back('{16'hC000, 16'hC000, 16'h4400});
    vecs.push_back('{16'h3800, 16'h3800, 16'h3400});
    vecs.push_back('{16'h0400, 16'h3C00, 16'h0400});
    vecs.push_back('{16'h7BFF, 16'h3C01, 16'h7C00});
    vecs.push_back('{16'h0000, 16'h7C01, 16'h7E00});
    vecs.push_back('{16'h8000, 16'h4500, 16'h8000});
    vecs.push_back('{16'h7C00, 16'hFC00, 16'hFC00});

    stream_a = '{16'hD5C7, 16'h4E6E, 16'h3A91, 16'hC4D2, 16'h2F0B,
                 16'h5BFE, 16'hB3C4, 16'h4801, 16'h1C55, 16'hE47A};
    stream_b = '{16'h528F, 16'h5502, 16'hBD33, 16'h48E1, 16'h3777,
                 16'h4C0F, 16'h8A6E, 16'h3FFF, 16'h2A08, 16'h5061};

    step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, "reset");
    step(1'b0, 1'b1, 16'h3C00, 16'h3C00, 16'h0, "reset_hold");

    // Explicit latency count, bounded.
    RESETn   = 1'b1;
    in_valid = 1'b1;
    A        = 16'h4000;
    B        = 16'h4000;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("latency_edges", 16'(n), 16'd3);
    chk("latency_product", product, 16'h4400);
    step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, "reset2");

    foreach (vecs[i]) step(1'b1, 1'b1, vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
    repeat (3) go(1'b0, 16'h0, 16'h0, "drain");

    for (int i = 0; i < 10; i++) begin
      go(1'b1, stream_a[i], stream_b[i], $sformatf("stream%0d", i));
      if (i == 4) go(1'b0, 16'h0, 16'h0, "stream_gap");
    end
    repeat (3) go(1'b0, 16'h0, 16'h0, "drain");

    // Reset while two results are in flight.
    go(1'b1, 16'h4200, 16'h4200, "flight0");
    go(1'b1, 16'h4400, 16'h3800, "flight1");
    step(1'b0, 1'b1, 16'h4600, 16'h4600, 16'h0, "midreset");
    repeat (4) go(1'b0, 16'h5555, 16'h5555, "post_reset_idle");
    go(1'b1, 16'hC400, 16'h4200, "post_reset_first");
    repeat (3) go(1'b0, 16'h0, 16'h0, "post_reset_drain");

    for (int i = 0; i < 400; i++) begin
      go(($urandom_range(4) != 0), rand_operand(), rand_operand(), "random");
    end
    repeat (3) go(1'b0, 16'h0, 16'h0, "drain");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
